// File: rtl/keypad_entry_if.sv
// rtl/keypad_entry_if.sv - keypad strobe in, operand handshake out
interface keypad_entry_if #(
  parameter int N          = 8,
  parameter int MAX_DIGITS = 3
);
  localparam int DW = $clog2(MAX_DIGITS + 1);

  logic          key_valid;
  logic [3:0]    key_code;
  logic          key_ready;
  logic [N-1:0]  mag;
  logic          neg;
  logic [DW-1:0] digits;
  logic          out_valid;
  logic          out_ready;
  logic          err;

  modport master (
    output key_valid, key_code, out_ready,
    input  key_ready, mag, neg, digits, out_valid, err
  );

  modport slave (
    input  key_valid, key_code, out_ready,
    output key_ready, mag, neg, digits, out_valid, err
  );
endinterface

// File: rtl/keypad_entry_unit.sv
// rtl/keypad_entry_unit.sv - decimal keypad entry into magnitude + sign with range check
module keypad_entry_unit #(
  parameter int N          = 8,
  parameter int MAX_DIGITS = 3
) (
  input logic           clk,
  input logic           rst,
  keypad_entry_if.slave kif
);
  localparam int DW = $clog2(MAX_DIGITS + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ENTRY = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [N+3:0] LIM_POS = (N+4)'((1 << (N-1)) - 1);
  localparam logic [N+3:0] LIM_NEG = (N+4)'(1 << (N-1));
  localparam logic [N-1:0] MAG_MIN = N'(1 << (N-1));

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  mag_q, mag_d;
  logic          neg_q, neg_d;
  logic [DW-1:0] digits_q, digits_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic [N+3:0]  mag_wide;
  logic [N+3:0]  cand;
  logic [N+3:0]  limit;

  // mag*10 + d via shift-add, wide enough that the range check cannot overflow
  assign mag_wide = {4'b0000, mag_q};
  assign cand     = (mag_wide << 3) + (mag_wide << 1) + {{N{1'b0}}, kif.key_code};
  assign limit    = neg_q ? LIM_NEG : LIM_POS;

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    neg_d    = neg_q;
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = 1'b0;

    if (state_q == HOLD) begin
      if (valid_q && kif.out_ready) begin
        state_d  = IDLE;
        mag_d    = '0;
        neg_d    = 1'b0;
        digits_d = '0;
        valid_d  = 1'b0;
      end
    end else if (kif.key_valid) begin
      case (kif.key_code)
        4'd10: begin
          if (neg_q && mag_q == MAG_MIN) begin
            err_d = 1'b1;
          end else begin
            neg_d   = ~neg_q;
            state_d = ENTRY;
          end
        end
        4'd11: begin
          if (digits_q != '0) begin
            mag_d    = mag_q / N'(10);
            digits_d = digits_q - DW'(1);
            if (digits_q == DW'(1) && !neg_q) state_d = IDLE;
          end
        end
        4'd12: begin
          state_d  = IDLE;
          mag_d    = '0;
          neg_d    = 1'b0;
          digits_d = '0;
        end
        4'd13: begin
          state_d = HOLD;
          valid_d = 1'b1;
          if (mag_q == '0) neg_d = 1'b0;
        end
        default: begin
          if (kif.key_code <= 4'd9) begin
            if (digits_q == '0 && kif.key_code == 4'd0) begin
              // leading zero: nothing to record
            end else if (digits_q < DW'(MAX_DIGITS) && cand <= limit) begin
              mag_d    = cand[N-1:0];
              digits_d = digits_q + DW'(1);
              state_d  = ENTRY;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mag_q    <= '0;
      neg_q    <= 1'b0;
      digits_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign kif.key_ready = (state_q != HOLD);
  assign kif.mag       = mag_q;
  assign kif.neg       = neg_q;
  assign kif.digits    = digits_q;
  assign kif.out_valid = valid_q;
  assign kif.err       = err_q;
endmodule
